alu_seq_multiplier: RTL and testbench

- Multi-cycle unsigned multiplier that acts as the initiator on the 32-bit ALU's operand/op interface.
- It drives alu_a, alu_b and alu_op, then consumes alu_result and alu_cout.
- It uses shift-and-add, issuing ALU ADD (010), left shift (101) and right shift (100) one per cycle.
- It returns the low WIDTH bits of the product plus an overflow flag over a valid/ready handshake, so the datapath gets multiply without a dedicated multiplier array.

---
 rtl/alu_seq_multiplier.sv | 148 ++++++++++++++
 tb/tb_alu_seq_multiplier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_multiplier.sv
// Shift-and-add unsigned multiplier that borrows the shared 32-bit ALU, one op per cycle.
// Returns the low WIDTH product bits plus an exact overflow flag over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for a request; in_ready high
//   EVAL  | inspect multiplier: finished, add, or shift only
//   ADD   | acc <= acc + mc through the ALU
//   SHL   | mc <= mc << 1, remember any bit pushed out the top
//   SHR   | mp <= mp >> 1
//   DONE  | result presented until out_ready
module alu_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_prod,
    output logic             out_ovf,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(3'b010);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(3'b101);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(3'b100);
    localparam logic [OPW-1:0] OP_IDLE = OPW'(3'b110);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EVAL = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic             r_lost;
    logic             r_ovf;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_EVAL;
            S_EVAL: begin
                if (r_mp == '0)     w_next_state = S_DONE;
                else if (r_mp[0])   w_next_state = S_ADD;
                else                w_next_state = S_SHL;
            end
            S_ADD:  w_next_state = S_SHL;
            S_SHL:  w_next_state = S_SHR;
            S_SHR:  w_next_state = S_EVAL;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE) && rst_n;
        out_valid = 1'b0;
        out_prod  = '0;
        out_ovf   = 1'b0;
        busy      = (r_state != S_IDLE);
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_IDLE;
        case (r_state)
            S_ADD: begin
                alu_a  = r_acc;
                alu_b  = r_mc;
                alu_op = OP_ADD;
            end
            S_SHL: begin
                alu_a  = r_mc;
                alu_op = OP_SHL;
            end
            S_SHR: begin
                alu_a  = r_mp;
                alu_op = OP_SHR;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_prod  = r_acc;
                out_ovf   = r_ovf;
            end
            default: ;
        endcase
    end

    // Partial products are nonnegative, so a carry or an add after mc lost a bit is a true overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mc   <= '0;
            r_mp   <= '0;
            r_lost <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc  <= '0;
                        r_mc   <= in_a;
                        r_mp   <= in_b;
                        r_lost <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_acc <= alu_result;
                    r_ovf <= r_ovf | alu_cout | r_lost;
                end
                S_SHL: begin
                    r_lost <= r_lost | r_mc[WIDTH-1];
                    r_mc   <= alu_result;
                end
                S_SHR: r_mp <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed and random checks of alu_seq_multiplier against a behavioural ALU
// and hand-computed products, overflow flags and latencies.
module tb_alu_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;
    logic        out_ovf;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_cout;

    int n_vec = 0;
    int n_err = 0;

    alu_seq_multiplier #(.WIDTH(32), .OPW(3)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .out_ovf    (out_ovf),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [32:0] w_sum;
        w_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = 32'h0;
        alu_cout   = 1'b0;
        case (alu_op)
            3'b010: begin
                alu_result = w_sum[31:0];
                alu_cout   = w_sum[32];
            end
            3'b101: alu_result = {alu_a[30:0], 1'b0};
            3'b100: alu_result = {1'b0, alu_a[31:1]};
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return 3 * n + $countones(b) + 2;
    endfunction

    // Accepts one request and returns #1 after the edge where out_valid first rises.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            output int lat, output int nops, output logic [63:0] ops);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", {63'h0, in_ready}, 64'h1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 1;
        nops = 0;
        ops  = '0;
        while (!out_valid && lat < 300) begin
            if (alu_op != 3'b110) begin
                ops = {ops[60:0], alu_op};
                nops++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input int stall);
        out_ready = 1'b0;
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_p, input logic exp_o, input int exp_l);
        int          lat;
        int          nops;
        logic [63:0] ops;
        start_op(a, b, lat, nops, ops);
        chk({tag, "_prod"}, {32'h0, out_prod}, {32'h0, exp_p});
        chk({tag, "_ovf"}, {63'h0, out_ovf}, {63'h0, exp_o});
        chk({tag, "_lat"}, 64'(lat), 64'(exp_l));
        finish_op(0);
    endtask

    initial begin
        int          lat;
        int          nops;
        logic [63:0] ops;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] full;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_alu_op", {61'h0, alu_op}, 64'h6);
        chk("rst_alu_a", {32'h0, alu_a}, 64'h0);
        chk("rst_out_prod", {32'h0, out_prod}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

        // 3*5 with the exact ALU op trace
        start_op(32'd3, 32'd5, lat, nops, ops);
        chk("b5_prod", {32'h0, out_prod}, 64'd15);
        chk("b5_ovf", {63'h0, out_ovf}, 64'h0);
        chk("b5_lat", 64'(lat), 64'd13);
        chk("b5_nops", 64'(nops), 64'd8);
        chk("b5_ops", ops, {40'h0, 24'b010_101_100_101_100_010_101_100});
        finish_op(0);

        start_op(32'hDEADBEEF, 32'h0, lat, nops, ops);
        chk("b0_prod", {32'h0, out_prod}, 64'h0);
        chk("b0_ovf", {63'h0, out_ovf}, 64'h0);
        chk("b0_lat", 64'(lat), 64'd2);
        chk("b0_nops", 64'(nops), 64'd0);
        finish_op(0);

        vec("lost", 32'h80000001, 32'd3, 32'h80000003, 1'b1, 10);
        vec("sq16", 32'h00010000, 32'h00010000, 32'h0, 1'b1, 3 * 17 + 1 + 2);
        vec("ones1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 6);
        vec("carry", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b1, 10);
        vec("maxb", 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 130);

        // backpressure with an ignored request while DONE
        start_op(32'h1234, 32'h10, lat, nops, ops);
        chk("bp_lat", 64'(lat), 64'd18);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_a     = 32'd9;
            in_b     = 32'd9;
            @(posedge clk);
            #1;
            chk("bp_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_prod", {32'h0, out_prod}, 64'h12340);
            chk("bp_ovf", {63'h0, out_ovf}, 64'h0);
            chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
            chk("bp_busy", {63'h0, busy}, 64'h1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_valid", {63'h0, out_valid}, 64'h0);
        chk("bp_rel_in_ready", {63'h0, in_ready}, 64'h1);
        chk("bp_rel_busy", {63'h0, busy}, 64'h0);

        // reset at cycle 40 of a long operation, with a busy-time request ignored
        @(negedge clk);
        in_a     = 32'd7;
        in_b     = 32'hFFFFFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 32'd2;
        in_b = 32'd2;
        repeat (38) @(posedge clk);
        #1;
        chk("mid_busy", {63'h0, busy}, 64'h1);
        chk("mid_in_ready", {63'h0, in_ready}, 64'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", {63'h0, out_valid}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_alu_op", {61'h0, alu_op}, 64'h6);
        chk("abort_alu_a", {32'h0, alu_a}, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", {63'h0, in_ready}, 64'h1);
        vec("after_rst", 32'd6, 32'd7, 32'd42, 1'b0, 14);

        for (int k = 0; k < 200; k++) begin
            ra   = $urandom;
            rb   = $urandom >> $urandom_range(0, 31);
            full = {32'h0, ra} * {32'h0, rb};
            start_op(ra, rb, lat, nops, ops);
            chk("rnd_prod", {32'h0, out_prod}, {32'h0, full[31:0]});
            chk("rnd_ovf", {63'h0, out_ovf}, {63'h0, (full[63:32] != 32'h0)});
            chk("rnd_lat", 64'(lat), 64'(exp_lat(rb)));
            finish_op($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
